alu_ctrl: RTL

- Sequential command front-end that drives the combinational 32-bit ALU (a, b, op_code -> y, O/C/Z/N).
- Accepts register-based commands over a valid/ready interface and reads operands from an internal register file or an immediate.
- Presents operands to the ALU, captures the result and flags, writes the result back to the register file, and returns a response over a second valid/ready interface.

---
 rtl/alu_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl
//  Description : Command front-end for a combinational 32-bit ALU. It reads
//                operands from a small register file, captures the ALU result
//                and flags, writes the result back, and returns a response.
//  Revision    : 1.0
// ============================================================================
module alu_ctrl #(
    parameter int NREGS = 4,
    parameter int RW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [RW-1:0] cmd_rd,
    input  logic [RW-1:0] cmd_rs1,
    input  logic [RW-1:0] cmd_rs2,
    input  logic          cmd_use_imm,
    input  logic [31:0]   cmd_imm,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [3:0]    alu_op,
    input  logic [31:0]   alu_y,
    input  logic          alu_o,
    input  logic          alu_c,
    input  logic          alu_z,
    input  logic          alu_n,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic [3:0]    rsp_flags,
    output logic [3:0]    flags_q
);

    localparam logic [3:0] c_op_read = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_regs [NREGS];
    logic [RW-1:0]   r_rd;
    logic            r_is_read;
    logic            w_accept;
    logic [3:0]      w_alu_flags;

    assign cmd_ready   = (r_state == ST_IDLE) && !rst;
    assign rsp_valid   = (r_state == ST_RESP);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_alu_flags = {alu_o, alu_c, alu_z, alu_n};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_EXEC;
            ST_EXEC:                w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 4'h0;
            r_rd      <= '0;
            r_is_read <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            flags_q   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Operands are captured at accept, so rd may alias rs1/rs2 safely.
            if (w_accept) begin
                alu_a     <= r_regs[cmd_rs1];
                alu_b     <= cmd_use_imm ? cmd_imm : r_regs[cmd_rs2];
                alu_op    <= cmd_op;
                r_rd      <= cmd_rd;
                r_is_read <= (cmd_op == c_op_read);
            end
            if (r_state == ST_EXEC) begin
                if (r_is_read) begin
                    rsp_data  <= alu_a;
                    rsp_flags <= flags_q;
                end else begin
                    r_regs[r_rd] <= alu_y;
                    flags_q      <= w_alu_flags;
                    rsp_data     <= alu_y;
                    rsp_flags    <= w_alu_flags;
                end
            end
        end
    end

endmodule
`default_nettype wire
